// File: rtl/multdiv_ctrl.sv
// Sequencing controller for the iterative 32-bit multiply/divide datapath.
// Latches operands, drives the shared iteration count and captures the selected result.
module multdiv_ctrl #(
  parameter int MULT_CYCLES = 17,
  parameter int DIV_CYCLES  = 33
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        ctrl_MULT,
  input  logic        ctrl_DIV,
  input  logic [31:0] data_operandA,
  input  logic [31:0] data_operandB,
  input  logic [31:0] mult_result,
  input  logic        mult_exception,
  input  logic [31:0] div_quotient,
  input  logic        div_exception,
  output logic [31:0] op_a,
  output logic [31:0] op_b,
  output logic [31:0] count,
  output logic        sel_div,
  output logic        busy,
  output logic [31:0] data_result,
  output logic        data_exception,
  output logic        data_resultRDY
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    RUN_MULT = 2'd1,
    RUN_DIV  = 2'd2
  } state_t;

  localparam logic [31:0] MULT_LAST = 32'(MULT_CYCLES);
  localparam logic [31:0] DIV_LAST  = 32'(DIV_CYCLES);

  state_t      state_r;
  logic [31:0] op_a_r;
  logic [31:0] op_b_r;
  logic [31:0] count_r;
  logic        sel_div_r;
  logic        busy_r;
  logic [31:0] result_r;
  logic        exception_r;
  logic        rdy_r;
  logic        start_s;

  // Any request restarts the controller, even mid-run or on a completion edge.
  assign start_s = ctrl_MULT | ctrl_DIV;

  // Run sequencing: start/abort, count advance, result capture and RDY pulse.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r     <= IDLE;
      op_a_r      <= 32'd0;
      op_b_r      <= 32'd0;
      count_r     <= 32'd0;
      sel_div_r   <= 1'b0;
      busy_r      <= 1'b0;
      result_r    <= 32'd0;
      exception_r <= 1'b0;
      rdy_r       <= 1'b0;
    end else begin
      rdy_r <= 1'b0;
      if (start_s) begin
        // Multiply has priority when both requests arrive together.
        op_a_r    <= data_operandA;
        op_b_r    <= data_operandB;
        count_r   <= 32'd0;
        sel_div_r <= ~ctrl_MULT;
        busy_r    <= 1'b1;
        state_r   <= ctrl_MULT ? RUN_MULT : RUN_DIV;
      end else begin
        case (state_r)
          IDLE: begin
            busy_r <= 1'b0;
          end
          RUN_MULT: begin
            if (count_r == MULT_LAST) begin
              result_r    <= mult_result;
              exception_r <= mult_exception;
              rdy_r       <= 1'b1;
              busy_r      <= 1'b0;
              state_r     <= IDLE;
            end else begin
              count_r <= count_r + 32'd1;
            end
          end
          RUN_DIV: begin
            if (count_r == DIV_LAST) begin
              result_r    <= div_quotient;
              exception_r <= div_exception;
              rdy_r       <= 1'b1;
              busy_r      <= 1'b0;
              state_r     <= IDLE;
            end else begin
              count_r <= count_r + 32'd1;
            end
          end
          default: begin
            busy_r  <= 1'b0;
            state_r <= IDLE;
          end
        endcase
      end
    end
  end

  assign op_a           = op_a_r;
  assign op_b           = op_b_r;
  assign count          = count_r;
  assign sel_div        = sel_div_r;
  assign busy           = busy_r;
  assign data_result    = result_r;
  assign data_exception = exception_r;
  assign data_resultRDY = rdy_r;

endmodule

// File: tb/tb_multdiv_ctrl.sv
// Scoreboard bench for multdiv_ctrl: a stub datapath presents valid results only at
// the final count, stimulus pushes hand-computed expectations, a monitor checks RDY.
module tb_multdiv_ctrl;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        ctrl_MULT, ctrl_DIV;
  logic [31:0] data_operandA, data_operandB;
  logic [31:0] mult_result, div_quotient;
  logic        mult_exception, div_exception;
  logic [31:0] op_a, op_b, count, data_result;
  logic        sel_div, busy, data_exception, data_resultRDY;

  typedef struct {
    logic [31:0] res;
    logic        exc;
    int          cyc;
    string       name;
  } exp_t;

  exp_t sb_q[$];
  int   checks = 0;
  int   failures = 0;
  int   edge_cnt = 0;
  int   e0, e1;

  multdiv_ctrl dut (
    .clk(clk), .reset_n(reset_n), .ctrl_MULT(ctrl_MULT), .ctrl_DIV(ctrl_DIV),
    .data_operandA(data_operandA), .data_operandB(data_operandB),
    .mult_result(mult_result), .mult_exception(mult_exception),
    .div_quotient(div_quotient), .div_exception(div_exception),
    .op_a(op_a), .op_b(op_b), .count(count), .sel_div(sel_div), .busy(busy),
    .data_result(data_result), .data_exception(data_exception),
    .data_resultRDY(data_resultRDY)
  );

  always #5 clk = ~clk;

  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  // Stub datapath: garbage except on the cycle the real result would be valid.
  always_comb begin
    mult_result    = 32'hDEADBEEF;
    mult_exception = 1'b1;
    div_quotient   = 32'hBADC0FFE;
    div_exception  = 1'b1;
    if (busy && !sel_div && count == 32'd17) begin
      mult_result    = 32'(op_a * op_b);
      mult_exception = 1'b0;
    end
    if (busy && sel_div && count == 32'd33) begin
      div_quotient  = (op_b == 32'd0) ? 32'd0 : 32'($signed(op_a) / $signed(op_b));
      div_exception = (op_b == 32'd0);
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", nm, act, req);
    end
  endtask

  // Monitor: every RDY pulse must match the next expectation, including its edge.
  always @(negedge clk) begin
    if (reset_n === 1'b1 && data_resultRDY === 1'b1) begin
      if (sb_q.size() == 0) begin
        chk("unexpected_rdy", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        chk({e.name, "_result"}, data_result, e.res);
        chk({e.name, "_exc"}, {31'd0, data_exception}, {31'd0, e.exc});
        chk({e.name, "_edge"}, 32'(edge_cnt), 32'(e.cyc));
        chk({e.name, "_busy"}, {31'd0, busy}, 32'd0);
      end
    end
  end

  task automatic start(input logic m, input logic d, input logic [31:0] a,
                       input logic [31:0] b, output int e);
    @(negedge clk);
    ctrl_MULT = m; ctrl_DIV = d; data_operandA = a; data_operandB = b;
    @(posedge clk);
    #1;
    ctrl_MULT = 1'b0; ctrl_DIV = 1'b0;
    e = edge_cnt;
  endtask

  task automatic wait_edges(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_count(input logic [31:0] target, input int budget);
    for (int i = 0; i < budget; i++) begin
      if (count == target) break;
      @(posedge clk);
      #1;
    end
    chk("wait_count", count, target);
  endtask

  task automatic push(input logic [31:0] r, input logic x, input int c, input string n);
    exp_t e;
    e.res = r; e.exc = x; e.cyc = c; e.name = n;
    sb_q.push_back(e);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_op_a"}, op_a, 32'd0);
    chk({tag, "_op_b"}, op_b, 32'd0);
    chk({tag, "_count"}, count, 32'd0);
    chk({tag, "_flags"}, {28'd0, sel_div, busy, data_exception, data_resultRDY}, 32'd0);
    chk({tag, "_result"}, data_result, 32'd0);
  endtask

  initial begin
    reset_n = 1'b0; ctrl_MULT = 1'b0; ctrl_DIV = 1'b0;
    data_operandA = 32'd0; data_operandB = 32'd0;
    #12;
    chk_reset_vals("reset");
    @(negedge clk);
    reset_n = 1'b1;
    wait_edges(2);

    // Divide 100/7 with count walk.
    start(1'b0, 1'b1, 32'd100, 32'd7, e0);
    push(32'd14, 1'b0, e0 + 34, "div100_7");
    chk("div_sel", {31'd0, sel_div}, 32'd1);
    for (int k = 0; k <= 33; k++) begin
      chk("div_count_walk", count, 32'(k));
      chk("div_busy_run", {31'd0, busy}, 32'd1);
      if (k < 33) wait_edges(1);
    end
    wait_edges(4);
    chk("div_count_hold", count, 32'd33);
    chk("div_busy_idle", {31'd0, busy}, 32'd0);

    // Multiply -6*7.
    start(1'b1, 1'b0, 32'hFFFFFFFA, 32'd7, e0);
    push(32'hFFFFFFD6, 1'b0, e0 + 18, "mult_m6_7");
    wait_edges(22);
    chk("mult_count_hold", count, 32'd17);

    // Divide by zero.
    start(1'b0, 1'b1, 32'd5, 32'd0, e0);
    push(32'd0, 1'b1, e0 + 34, "div5_0");
    wait_edges(38);

    // Abort a divide with a multiply at count 10.
    start(1'b0, 1'b1, 32'd100, 32'd7, e0);
    wait_count(32'd10, 40);
    chk("abort_op_a_held", op_a, 32'd100);
    start(1'b1, 1'b0, 32'd3, 32'd4, e1);
    push(32'd12, 1'b0, e1 + 18, "abort_mult3_4");
    chk("abort_op_a_new", op_a, 32'd3);
    chk("abort_count0", count, 32'd0);
    wait_edges(40);

    // Simultaneous requests: multiply wins.
    start(1'b1, 1'b1, 32'd8, 32'd2, e0);
    push(32'd16, 1'b0, e0 + 18, "both8_2");
    chk("both_sel", {31'd0, sel_div}, 32'd0);
    wait_edges(22);

    // Start coincident with the completion edge discards that completion.
    start(1'b1, 1'b0, 32'd9, 32'd9, e0);
    wait_edges(17);
    start(1'b1, 1'b0, 32'd2, 32'd3, e1);
    chk("coincide_edge", 32'(e1), 32'(e0 + 18));
    push(32'd6, 1'b0, e1 + 18, "coincide2_3");
    wait_edges(22);

    // Start while RDY is high.
    start(1'b1, 1'b0, 32'd5, 32'd5, e0);
    push(32'd25, 1'b0, e0 + 18, "mult5_5");
    wait_edges(18);
    start(1'b0, 1'b1, 32'd21, 32'd4, e1);
    chk("onrdy_rdy_drop", {31'd0, data_resultRDY}, 32'd0);
    push(32'd5, 1'b0, e1 + 34, "div21_4");
    wait_edges(38);

    // Asynchronous reset mid-divide.
    start(1'b0, 1'b1, 32'd1000, 32'd3, e0);
    wait_count(32'd20, 40);
    #2;
    reset_n = 1'b0;
    #1;
    chk_reset_vals("midrun_reset");
    wait_edges(2);
    @(negedge clk);
    reset_n = 1'b1;
    wait_edges(40);

    for (int i = 0; i < 100 && sb_q.size() != 0; i++) @(posedge clk);
    chk("scoreboard_empty", 32'(sb_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
